coeff_token_dec: RTL and testbench
==================================

Name: coeff_token_dec

Overview:
- Bit-serial CAVLC coeff_token decoder. The receive-side counterpart of the coeff_token encoder in the H.264 entropy path.
- Consumes a bitstream one bit per cycle, MSB-first, under a valid/ready handshake.
- Decodes one coeff_token per start command against the table selected by NC (H.264 Table 9-5).
- Returns TotalCoeff, TrailOneNum, and the consumed code length/bits to the downstream CAVLC parser, which then reads the level and run fields.

Parameters:
- MAX_LEN, 16, longest legal coeff_token codeword in bits; exceeding it is a decode error.
- CNT_W, 5, width of the length counter and the CodeLength output.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to decode one token; accepted only in IDLE.
- NC  in  3  table select, latched on accepted start:
  - 0: 0<=nC<2
  - 1: 2<=nC<4
  - 2: 4<=nC<8
  - 3: nC>=8 (6-bit FLC)
  - 4: nC=-1 (chroma DC)
  - 5..7: illegal
- bit_in  in  1  next bitstream bit.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  decoder accepts a bit this cycle; a bit is consumed when bit_valid && bit_ready.
- busy  out  1  high in any state other than IDLE.
- dec_valid  out  1  decoded result valid; held until accepted.
- dec_ready  in  1  downstream accepts the result.
- dec_err  out  1  qualifies dec_valid. 1 means no legal codeword was found (illegal NC, or MAX_LEN bits with no match).
- TotalCoeff  out  5  decoded total coefficients, 0..16.
- TrailOneNum  out  2  decoded trailing ones, 0..3.
- CodeLength  out  5  number of bits consumed, 1..16. On error, bits consumed so far.
- CodeBit  out  16  consumed bits, right-aligned, first bit at position CodeLength-1.

Behaviour:
- Reset (async, immediate) values:
  - FSM = IDLE.
  - bit_ready = 0, busy = 0, dec_valid = 0, dec_err = 0.
  - TotalCoeff = 0, TrailOneNum = 0, CodeLength = 0, CodeBit = 0.
  - Internal shift register and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches NC, clears shift register and counter.
  - If NC<=4, go to SHIFT.
  - If NC>=5, go to DONE with dec_err=1 and CodeLength=0.
  - start is ignored in every other state.
- SHIFT:
  - bit_ready=1 combinationally.
  - On each accepted bit: sr <= {sr[14:0], bit_in}; len <= len+1.
  - The match check is combinational on the next (sr, len) against the NC table.
  - On a match: register TotalCoeff, TrailOneNum, CodeLength = len+1, CodeBit = next sr; go to DONE.
  - NC=3 (FLC) has no early match. After exactly 6 bits:
    - code 6'b000011 gives TC=0, T1=0.
    - Otherwise TC = code[5:2]+1 and T1 = code[1:0].
    - T1 > TC (e.g. 000010) is illegal and sets dec_err.
  - No match with len+1 == MAX_LEN: DONE with dec_err=1, CodeLength=16.
  - No consumed bit: state holds; stalls of any length are allowed.
- Latency: dec_valid rises on the cycle after the final bit is accepted.
- DONE:
  - dec_valid=1 and bit_ready=0; result registers are stable.
  - dec_valid && dec_ready: return to IDLE, drop dec_valid the next cycle.
  - start on that same cycle is ignored; the upstream re-asserts it in IDLE.
- busy: 1 in SHIFT and DONE.
- Bit consumption: no bits are consumed beyond the codeword. The bit after the codeword stays on bit_in for the next parser stage.
- Reset mid-decode: an asserted rst aborts immediately to IDLE. The partial token is discarded and no dec_valid is produced.
- Width rules:
  - len saturates at 16; overflow never occurs because MAX_LEN forces DONE.
  - TotalCoeff never exceeds 16, or 4 when NC=4.

Test Plan:
- NC=0, bits "1" -> dec_valid one cycle after the bit; TC=0, T1=0, CodeLength=1, CodeBit=0x0001, dec_err=0.
- NC=0, bits "000101" with bit_valid gaps of 3 cycles between bits -> TC=1, T1=0, CodeLength=6, CodeBit=0x0005. bit_ready drops after the 6th bit.
- NC=1, bits "11"; then NC=4, bits "01"; then NC=4, bits "1" -> first two each give TC=0/T1=0 with length 2, the third gives TC=1/T1=1 with length 1. All three back-to-back with dec_ready=1.
- NC=3, bits "000011" -> TC=0, T1=0, len 6. Bits "001110" -> TC=4, T1=2, len 6. Bits "000010" -> dec_err=1.
- NC=0, 16 zeros -> dec_valid with dec_err=1, CodeLength=16. NC=6 on start -> dec_err=1 on the next cycle with no bits consumed.
- Assert rst after 3 bits of a token, then start NC=0 with "01" -> no stale dec_valid; result TC=1, T1=1, CodeLength=2. Holding dec_ready=0 for 5 cycles keeps all outputs stable.

Source files
------------

// File: rtl/coeff_token_dec.sv
// Bit-serial CAVLC coeff_token decoder (H.264 Table 9-5): one bit per cycle, MSB first.
// Returns TotalCoeff/TrailOneNum plus the consumed code length and bits to the CAVLC parser.
module coeff_token_dec #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         NC,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic               busy,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic               dec_err,
  output logic [4:0]         TotalCoeff,
  output logic [1:0]         TrailOneNum,
  output logic [CNT_W-1:0]   CodeLength,
  output logic [MAX_LEN-1:0] CodeBit
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // VLC tables indexed [nC class][TotalCoeff*4 + TrailingOnes]; length 0 marks an unused slot.
  localparam logic [4:0] VLC_LEN [3][68] = '{
    '{ 1, 0, 0, 0,   6, 2, 0, 0,   8, 6, 3, 0,   9, 8, 7, 5,
      10, 9, 8, 6,  11,10, 9, 7,  13,11,10, 8,  13,13,11, 9,
      13,13,13,10,  14,14,13,11,  14,14,14,13,  15,15,14,14,
      15,15,15,14,  16,15,15,15,  16,16,16,15,  16,16,16,16,
      16,16,16,16},
    '{ 2, 0, 0, 0,   6, 2, 0, 0,   6, 5, 3, 0,   7, 6, 6, 4,
       8, 6, 6, 4,   8, 7, 7, 5,   9, 8, 8, 6,  11, 9, 9, 6,
      11,11,11, 7,  12,11,11, 9,  12,12,12,11,  12,12,12,11,
      13,13,13,12,  13,13,13,13,  13,14,13,13,  14,14,14,13,
      14,14,14,14},
    '{ 4, 0, 0, 0,   6, 4, 0, 0,   6, 5, 4, 0,   6, 5, 5, 4,
       7, 5, 5, 4,   7, 5, 5, 4,   7, 6, 6, 4,   7, 6, 6, 4,
       8, 7, 7, 5,   8, 8, 7, 6,   9, 8, 8, 7,   9, 9, 8, 8,
       9, 9, 9, 8,  10, 9, 9, 9,  10,10,10,10,  10,10,10,10,
      10,10,10,10}
  };

  localparam logic [3:0] VLC_BITS [3][68] = '{
    '{ 1, 0, 0, 0,   5, 1, 0, 0,   7, 4, 1, 0,   7, 6, 5, 3,
       7, 6, 5, 3,   7, 6, 5, 4,  15, 6, 5, 4,  11,14, 5, 4,
       8,10,13, 4,  15,14, 9, 4,  11,10,13,12,  15,14, 9,12,
      11,10,13, 8,  15, 1, 9,12,  11,14,13, 8,   7,10, 9,12,
       4, 6, 5, 8},
    '{ 3, 0, 0, 0,  11, 2, 0, 0,   7, 7, 3, 0,   7,10, 9, 5,
       7, 6, 5, 4,   4, 6, 5, 6,   7, 6, 5, 8,  15, 6, 5, 4,
      11,14,13, 4,  15,10, 9, 4,  11,14,13,12,   8,10, 9, 8,
      15,14,13,12,  11,10, 9,12,   7,11, 6, 8,   9, 8,10, 1,
       7, 6, 5, 4},
    '{15, 0, 0, 0,  15,14, 0, 0,  11,15,13, 0,   8,12,14,12,
      15,10,11,11,  11, 8, 9,10,   9,14,13, 9,   8,10, 9, 8,
      15,14,13,13,  11,14,10,12,  15,10,13,12,  11,14, 9,12,
       8,10,13, 8,  13, 7, 9,12,   9,12,11,10,   5, 8, 7, 6,
       1, 4, 3, 2}
  };

  localparam logic [4:0] CDC_LEN  [20] = '{2,0,0,0, 6,1,0,0, 6,6,3,0, 6,7,7,6, 6,8,8,7};
  localparam logic [3:0] CDC_BITS [20] = '{1,0,0,0, 7,1,0,0, 4,6,1,0, 3,3,2,5, 2,3,2,0};

  state_t             state_q, state_d;
  logic [2:0]         nc_q, nc_d;
  logic [MAX_LEN-1:0] sr_q, sr_d, sr_nx;
  logic [CNT_W-1:0]   len_q, len_d, len_nx;
  logic [4:0]         tc_q, tc_d, hit_tc;
  logic [1:0]         t1_q, t1_d, hit_t1;
  logic [CNT_W-1:0]   clen_q, clen_d;
  logic [MAX_LEN-1:0] cbit_q, cbit_d;
  logic               err_q, err_d;
  logic               hit, bad;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      nc_q    <= '0;
      sr_q    <= '0;
      len_q   <= '0;
      tc_q    <= '0;
      t1_q    <= '0;
      clen_q  <= '0;
      cbit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nc_q    <= nc_d;
      sr_q    <= sr_d;
      len_q   <= len_d;
      tc_q    <= tc_d;
      t1_q    <= t1_d;
      clen_q  <= clen_d;
      cbit_q  <= cbit_d;
      err_q   <= err_d;
    end
  end

  // Match check runs on the (sr, len) that would result from accepting the current bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    sr_nx  = {sr_q[MAX_LEN-2:0], bit_in};
    len_nx = len_q + CNT_W'(1);
    hit    = 1'b0;
    bad    = 1'b0;
    hit_tc = '0;
    hit_t1 = '0;
    if (nc_q == 3'd3) begin
      if (len_nx == CNT_W'(6)) begin
        hit = 1'b1;
        if (sr_nx[5:0] != 6'b000011) begin
          hit_tc = 5'(sr_nx[5:2]) + 5'd1;
          hit_t1 = sr_nx[1:0];
          bad    = {3'b000, hit_t1} > hit_tc;
        end
      end
    end else if (nc_q == 3'd4) begin
      for (int i = 0; i < 20; i++) begin
        if (CDC_LEN[i] == len_nx && MAX_LEN'(CDC_BITS[i]) == sr_nx) begin
          hit    = 1'b1;
          hit_tc = 5'(i >> 2);
          hit_t1 = 2'(i);
        end
      end
    end else if (nc_q <= 3'd2) begin
      for (int i = 0; i < 68; i++) begin
        if (VLC_LEN[nc_q[1:0]][i] == len_nx && MAX_LEN'(VLC_BITS[nc_q[1:0]][i]) == sr_nx) begin
          hit    = 1'b1;
          hit_tc = 5'(i >> 2);
          hit_t1 = 2'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    nc_d    = nc_q;
    sr_d    = sr_q;
    len_d   = len_q;
    tc_d    = tc_q;
    t1_d    = t1_q;
    clen_d  = clen_q;
    cbit_d  = cbit_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        nc_d  = NC;
        sr_d  = '0;
        len_d = '0;
        err_d = 1'b0;
        if (NC <= 3'd4) begin
          state_d = SHIFT;
        end else begin
          state_d = DONE;
          err_d   = 1'b1;
          tc_d    = '0;
          t1_d    = '0;
          clen_d  = '0;
          cbit_d  = '0;
        end
      end
      SHIFT: if (bit_valid) begin
        sr_d  = sr_nx;
        len_d = len_nx;
        if (hit || len_nx == CNT_W'(MAX_LEN)) begin
          state_d = DONE;
          err_d   = bad || !hit;
          tc_d    = (hit && !bad) ? hit_tc : 5'd0;
          t1_d    = (hit && !bad) ? hit_t1 : 2'd0;
          clen_d  = len_nx;
          cbit_d  = sr_nx;
        end
      end
      DONE: if (dec_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bit_ready   = (state_q == SHIFT);
  assign busy        = (state_q != IDLE);
  assign dec_valid   = (state_q == DONE);
  assign dec_err     = err_q;
  assign TotalCoeff  = tc_q;
  assign TrailOneNum = t1_q;
  assign CodeLength  = clen_q;
  assign CodeBit     = cbit_q;

endmodule

// File: tb/tb_coeff_token_dec.sv
// Directed testbench for coeff_token_dec: table of codewords with hand-derived results,
// plus hand-written sequences for reset abort, result hold and ignored start.
module tb_coeff_token_dec;

  logic        clk = 1'b0;
  logic        rst, start, bit_in, bit_valid, dec_ready;
  logic [2:0]  NC;
  logic        bit_ready, busy, dec_valid, dec_err;
  logic [4:0]  TotalCoeff;
  logic [1:0]  TrailOneNum;
  logic [4:0]  CodeLength;
  logic [15:0] CodeBit;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  nc;
    int          nbits;
    logic [15:0] bits;
    int          gap;
    logic        err;
    logic [4:0]  tc;
    logic [1:0]  t1;
    logic [4:0]  len;
  } vec_t;

  vec_t vecs[$];

  coeff_token_dec #(.MAX_LEN(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .NC         (NC),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .busy       (busy),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_err    (dec_err),
    .TotalCoeff (TotalCoeff),
    .TrailOneNum(TrailOneNum),
    .CodeLength (CodeLength),
    .CodeBit    (CodeBit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] nc, input int nbits, input logic [15:0] bits,
                     input int gap, input logic err, input logic [4:0] tc,
                     input logic [1:0] t1, input logic [4:0] len);
    vec_t v;
    v.nc = nc; v.nbits = nbits; v.bits = bits; v.gap = gap;
    v.err = err; v.tc = tc; v.t1 = t1; v.len = len;
    vecs.push_back(v);
  endtask

  task automatic do_start(input logic [2:0] nc);
    @(negedge clk);
    start = 1'b1;
    NC    = nc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] bits, input int nbits, input int gap, input string tag);
    for (int k = 0; k < nbits; k++) begin
      repeat (gap) @(negedge clk);
      check($sformatf("%s bit_ready[%0d]", tag, k), 32'(bit_ready), 32'd1);
      bit_in    = bits[nbits-1-k];
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  task automatic check_result(input vec_t v, input string tag);
    check({tag, " dec_valid"}, 32'(dec_valid), 32'd1);
    check({tag, " bit_ready"}, 32'(bit_ready), 32'd0);
    check({tag, " busy"},      32'(busy),      32'd1);
    check({tag, " dec_err"},   32'(dec_err),   32'(v.err));
    check({tag, " CodeLength"}, 32'(CodeLength), 32'(v.len));
    check({tag, " CodeBit"},   32'(CodeBit),   32'(v.bits));
    if (!v.err) begin
      check({tag, " TotalCoeff"},  32'(TotalCoeff),  32'(v.tc));
      check({tag, " TrailOneNum"}, 32'(TrailOneNum), 32'(v.t1));
    end
  endtask

  initial begin
    vec_t h;
    rst = 1'b1; start = 1'b0; NC = 3'd0; bit_in = 1'b0; bit_valid = 1'b0; dec_ready = 1'b0;

    //  nc nbits bits      gap err tc  t1 len
    add(0,  1, 16'h0001, 0, 0,  0, 0,  1);
    add(0,  6, 16'h0005, 3, 0,  1, 0,  6);
    add(1,  2, 16'h0003, 0, 0,  0, 0,  2);
    add(4,  2, 16'h0001, 0, 0,  0, 0,  2);
    add(4,  1, 16'h0001, 0, 0,  1, 1,  1);
    add(3,  6, 16'h0003, 0, 0,  0, 0,  6);
    add(3,  6, 16'h000E, 0, 0,  4, 2,  6);
    add(3,  6, 16'h0002, 0, 1,  0, 0,  6);
    add(0, 16, 16'h0000, 0, 1,  0, 0, 16);
    add(6,  0, 16'h0000, 0, 1,  0, 0,  0);
    add(0,  5, 16'h0003, 1, 0,  3, 3,  5);
    add(0, 16, 16'h000F, 0, 0, 13, 0, 16);
    add(2,  4, 16'h000F, 0, 0,  0, 0,  4);
    add(2, 10, 16'h0001, 0, 0, 16, 0, 10);
    add(2,  5, 16'h000F, 0, 0,  2, 1,  5);
    add(4,  7, 16'h0000, 2, 0,  4, 3,  7);
    add(1, 13, 16'h0001, 0, 0, 15, 3, 13);
    add(1,  4, 16'h0005, 0, 0,  3, 3,  4);
    add(3,  6, 16'h003F, 0, 0, 16, 3,  6);

    repeat (2) @(negedge clk);
    check("reset bit_ready",   32'(bit_ready),   32'd0);
    check("reset busy",        32'(busy),        32'd0);
    check("reset dec_valid",   32'(dec_valid),   32'd0);
    check("reset dec_err",     32'(dec_err),     32'd0);
    check("reset TotalCoeff",  32'(TotalCoeff),  32'd0);
    check("reset TrailOneNum", 32'(TrailOneNum), 32'd0);
    check("reset CodeLength",  32'(CodeLength),  32'd0);
    check("reset CodeBit",     32'(CodeBit),     32'd0);
    rst = 1'b0;

    // Table vectors run back-to-back with dec_ready held high: each result lasts one cycle.
    dec_ready = 1'b1;
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      do_start(vecs[i].nc);
      feed(vecs[i].bits, vecs[i].nbits, vecs[i].gap, tag);
      check_result(vecs[i], tag);
      @(negedge clk);
      check({tag, " dec_valid drop"}, 32'(dec_valid), 32'd0);
      check({tag, " idle busy"},      32'(busy),      32'd0);
    end

    // Reset mid-decode: three bits into an NC=0 token, then abort.
    dec_ready = 1'b0;
    do_start(3'd0);
    feed(16'h0000, 3, 0, "abort");
    rst = 1'b1;
    #1;
    check("abort busy async",      32'(busy),      32'd0);
    check("abort bit_ready async", 32'(bit_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort no dec_valid", 32'(dec_valid),  32'd0);
    check("abort CodeLength",   32'(CodeLength), 32'd0);

    // Fresh token "01" with the result held for 5 cycles while start and bits are offered.
    h.nc = 3'd0; h.nbits = 2; h.bits = 16'h0001; h.gap = 0;
    h.err = 1'b0; h.tc = 5'd1; h.t1 = 2'd1; h.len = 5'd2;
    do_start(h.nc);
    feed(h.bits, h.nbits, h.gap, "hold");
    start = 1'b1; NC = 3'd1; bit_valid = 1'b1; bit_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_result(h, $sformatf("hold c%0d", c));
      @(negedge clk);
    end
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check("accept dec_valid drop", 32'(dec_valid), 32'd0);
    check("accept start ignored",  32'(busy),      32'd0);
    @(negedge clk);
    check("idle stays idle", 32'(busy), 32'd0);
    check("idle result kept", 32'(CodeLength), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
